fft_bf_sched: RTL and testbench
===============================

Name: fft_bf_sched

Overview:
Sequencer for one shared radix-2 DIF butterfly unit running an in-place N-point FFT out of a dual-port sample memory.
- Per stage, walks every butterfly index and generates read addresses, twiddle address and butterfly start.
- Delays the write-back addresses to match butterfly latency and drains the pipe between stages.
- Collects the butterfly quant_full flag per stage to drive block-floating-point scaling.
- Arbitrates the butterfly's complex multiplier between the FFT and an external complex-multiply requester.

Parameters:
LOGN, 8, log2 of FFT size N (N = 2**LOGN, range 2..12)
BF_LAT, 4, cycles from bf_start to valid p/q outputs of the butterfly

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
go  in  1  start-FFT pulse
busy  out  1  high from accepted go until done
done  out  1  one-cycle pulse, transform complete
rd_en  out  1  memory read strobe
rd_addr_a  out  LOGN  butterfly input a address
rd_addr_b  out  LOGN  butterfly input b address
tw_addr  out  LOGN-1  twiddle ROM address
bf_start  out  1  butterfly start, aligned with read data
wr_en  out  1  write-back strobe for p/q
wr_addr_a  out  LOGN  p write address
wr_addr_b  out  LOGN  q write address
quant_full  in  1  butterfly near-overflow flag, valid with wr_en
scale_en  out  1  shift-right-by-1 request for current stage inputs
scale_exp  out  $clog2(LOGN+1)  number of stages scaled so far
cm_req  in  1  external complex-multiply request, level
cm_gnt  out  1  grant; drives butterfly complex_mul_en

Behaviour:
- Reset: all outputs 0; state IDLE; go_pend = 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE: cm_gnt = cm_req. go with cm_gnt low -> ISSUE next cycle, busy = 1.
  - go while cm_gnt high -> latch go_pend; start the first cycle cm_req is low.
  - go while busy: ignored.
- ISSUE: stage s (0..LOGN-1), k counts 0..N/2-1, one butterfly per cycle, rd_en = 1.
  - span = N >> (s+1); j = k & (span-1); g = k >> (LOGN-1-s).
  - rd_addr_a = g*2*span + j; rd_addr_b = rd_addr_a + span; tw_addr = j << s.
  - k = N/2-1 -> DRAIN.
- Read latency 1: bf_start = rd_en delayed 1 cycle.
- wr_en / wr_addr_a / wr_addr_b = bf_start / rd addrs delayed by BF_LAT (total 1+BF_LAT from rd_en).
  - Implemented as a shift register; it is cleared only by reset, so writes are never dropped.
- DRAIN: exactly BF_LAT+1 cycles, so the last write lands before the next stage's first read.
  - s < LOGN-1 -> s++, k = 0, ISSUE.
  - s = LOGN-1 -> IDLE, done pulse on the same cycle busy falls.
  - Cycles go->done = LOGN*(N/2 + BF_LAT + 1) + 1.
- Scaling: sticky qf_stage set by quant_full & wr_en during stage s.
  - At the end of DRAIN of stage s, scale_en <= qf_stage; scale_exp += qf_stage; qf_stage cleared.
  - scale_en holds through the next stage.
  - On go: scale_en = 0, scale_exp = 0.
- Arbitration: cm_gnt only in IDLE with no go_pend start that cycle; FFT has priority once busy.
  - cm_req held during busy -> cm_gnt stays low until busy falls.
  - cm_req and go in the same IDLE cycle with cm_gnt low -> go wins, cm_gnt stays 0.
- Reset mid-transform: immediate return to IDLE, all outputs 0, no done.

Decomposition:
- Package fft_sched_pkg: state enum (IDLE, ISSUE, DRAIN); function bf_addr(LOGN, s, k) returning addr_a/addr_b/tw.
- One sub-module, bf_addr_delay: parameterised (depth, width) valid+data shift register for the write-back path.

Test Plan:
- LOGN=3, BF_LAT=4, go at cycle 0 -> stage0 rd (a,b,tw) = (0,4,0),(1,5,1),(2,6,2),(3,7,3) at cycles 1-4; stage1 = (0,2,0),(1,3,2),(4,6,0),(5,7,2) at cycles 10-13; stage2 = (0,1,0),(2,3,0),(4,5,0),(6,7,0) at cycles 19-22; done at cycle 28.
- Same run -> wr_en exactly 5 cycles after each rd_en with matching addresses; no rd_en while wr_en is pending for the previous stage.
- quant_full = 1 on one write of stage 0 only -> scale_en = 1 during stage 1, 0 during stage 2; final scale_exp = 1.
- cm_req high in IDLE -> cm_gnt = 1 next cycle; go pulsed while granted -> no rd_en until cm_req drops, then ISSUE starts the following cycle.
- cm_req asserted mid-stage -> cm_gnt = 0 until the cycle after done; go during busy -> ignored, exactly 1 done.
- rst_n low at stage 1, k=2 -> all outputs 0 asynchronously; after release, go runs a full clean transform with correct addresses from k=0, s=0.

Source files
------------

// File: rtl/fft_sched_pkg.sv
// Shared types and address helper for the FFT butterfly scheduler.
//   state_e   : scheduler FSM states
//   bf_addr_t : butterfly a/b read addresses and twiddle index
//   bf_addr() : radix-2 DIF in-place addressing for stage s, butterfly k
package fft_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam int MAX_LOGN = 12;

  typedef struct packed {
    logic [MAX_LOGN-1:0] a;
    logic [MAX_LOGN-1:0] b;
    logic [MAX_LOGN-1:0] tw;
  } bf_addr_t;

  // span = N >> (s+1); butterflies within a group are span apart, and
  // group g starts at g*2*span. Twiddle stride doubles each stage.
  function automatic bf_addr_t bf_addr(input int logn, input int s, input int k);
    bf_addr_t r;
    int sh, span, j, g, a;
    sh   = logn - 1 - s;
    span = 1 << sh;
    j    = k & (span - 1);
    g    = k >> sh;
    a    = (g << (sh + 1)) + j;
    r.a  = MAX_LOGN'(a);
    r.b  = MAX_LOGN'(a + span);
    r.tw = MAX_LOGN'(j << s);
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_sched_delay.sv
// Valid + data shift register aligning write-back addresses with the
// butterfly output. Cleared only by reset so in-flight writes always land.
//   in_vld/in_data   : entry (read strobe and read addresses)
//   out_vld/out_data : DEPTH cycles later
module bf_addr_delay #(
  parameter int DEPTH = 5,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0]        vld_pipe_q, vld_pipe_d;
  logic [DEPTH-1:0][W-1:0] data_pipe_q, data_pipe_d;

  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    data_pipe_d    = data_pipe_q;
    vld_pipe_d[0]  = in_vld;
    data_pipe_d[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      data_pipe_d[i] = data_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
    end
  end

  assign out_vld  = vld_pipe_q[DEPTH-1];
  assign out_data = data_pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_bf_sched.sv
// Sequencer for one shared radix-2 DIF butterfly running an in-place
// N-point FFT (N = 2**LOGN) out of a dual-port sample memory.
//   go/busy/done          : transform control
//   rd_en/rd_addr_*/tw    : one butterfly read per cycle in ISSUE
//   bf_start              : read strobe delayed by the memory read latency
//   wr_en/wr_addr_*       : write-back, 1+BF_LAT cycles after the read
//   quant_full            : butterfly near-overflow flag (with wr_en)
//   scale_en/scale_exp    : block-floating-point scaling state
//   cm_req/cm_gnt         : lend the butterfly multiplier while idle
module fft_bf_sched
  import fft_sched_pkg::*;
#(
  parameter int LOGN   = 8,
  parameter int BF_LAT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [LOGN-1:0]           rd_addr_a,
  output logic [LOGN-1:0]           rd_addr_b,
  output logic [LOGN-2:0]           tw_addr,
  output logic                      bf_start,
  output logic                      wr_en,
  output logic [LOGN-1:0]           wr_addr_a,
  output logic [LOGN-1:0]           wr_addr_b,
  input  logic                      quant_full,
  output logic                      scale_en,
  output logic [$clog2(LOGN+1)-1:0] scale_exp,
  input  logic                      cm_req,
  output logic                      cm_gnt
);

  localparam int SW = $clog2(LOGN);
  localparam int KW = LOGN - 1;
  localparam int DW = $clog2(BF_LAT + 2);
  localparam int EW = $clog2(LOGN + 1);
  localparam logic [SW-1:0] SLAST = SW'(LOGN - 1);
  localparam logic [DW-1:0] DLAST = DW'(BF_LAT);

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [EW-1:0] scale_exp_q, scale_exp_d;
  logic          go_pend_q, go_pend_d;
  logic          done_q, done_d;
  logic          cm_gnt_q, cm_gnt_d;
  logic          qf_stage_q, qf_stage_d;
  logic          scale_en_q, scale_en_d;
  logic          bf_start_q;
  logic          start, qf_now;
  bf_addr_t      addr;
  logic          addr_unused;
  logic [2*LOGN-1:0] wr_data;

  assign addr        = bf_addr(LOGN, int'(s_q), int'(k_q));
  assign addr_unused = ^addr;

  assign busy      = (state_q != IDLE);
  assign rd_en     = (state_q == ISSUE);
  assign rd_addr_a = rd_en ? addr.a[LOGN-1:0]  : '0;
  assign rd_addr_b = rd_en ? addr.b[LOGN-1:0]  : '0;
  assign tw_addr   = rd_en ? addr.tw[LOGN-2:0] : '0;
  assign bf_start  = bf_start_q;
  assign done      = done_q;
  assign cm_gnt    = cm_gnt_q;
  assign scale_en  = scale_en_q;
  assign scale_exp = scale_exp_q;

  // Includes the current cycle so the stage's final write (which can land
  // on the last DRAIN cycle) still counts toward this stage's flag.
  assign qf_now = qf_stage_q | (quant_full & wr_en);

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    k_d         = k_q;
    dcnt_d      = dcnt_q;
    go_pend_d   = go_pend_q;
    done_d      = 1'b0;
    cm_gnt_d    = 1'b0;
    qf_stage_d  = qf_now;
    scale_en_d  = scale_en_q;
    scale_exp_d = scale_exp_q;
    start       = 1'b0;
    case (state_q)
      IDLE: begin
        // A go that arrives while the multiplier is lent out waits until
        // the requester lets go; a fresh go beats a new request.
        start     = (go | go_pend_q) & (~cm_gnt_q | ~cm_req);
        go_pend_d = (go | go_pend_q) & ~start;
        cm_gnt_d  = cm_req & ~start;
        if (start) begin
          state_d     = ISSUE;
          s_d         = '0;
          k_d         = '0;
          qf_stage_d  = 1'b0;
          scale_en_d  = 1'b0;
          scale_exp_d = '0;
        end
      end
      ISSUE: begin
        k_d = k_q + KW'(1);
        if (k_q == '1) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end
      end
      DRAIN: begin
        // BF_LAT+1 cycles: the last read's write-back lands on the final one.
        dcnt_d = dcnt_q + DW'(1);
        if (dcnt_q == DLAST) begin
          scale_en_d  = qf_now;
          scale_exp_d = scale_exp_q + EW'(qf_now);
          qf_stage_d  = 1'b0;
          k_d         = '0;
          if (s_q == SLAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d     = s_q + SW'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      dcnt_q      <= '0;
      go_pend_q   <= 1'b0;
      done_q      <= 1'b0;
      cm_gnt_q    <= 1'b0;
      qf_stage_q  <= 1'b0;
      scale_en_q  <= 1'b0;
      scale_exp_q <= '0;
      bf_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      k_q         <= k_d;
      dcnt_q      <= dcnt_d;
      go_pend_q   <= go_pend_d;
      done_q      <= done_d;
      cm_gnt_q    <= cm_gnt_d;
      qf_stage_q  <= qf_stage_d;
      scale_en_q  <= scale_en_d;
      scale_exp_q <= scale_exp_d;
      bf_start_q  <= rd_en;
    end
  end

  bf_addr_delay #(.DEPTH(BF_LAT + 1), .W(2 * LOGN)) u_wr_dly (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_en),
    .in_data  ({rd_addr_a, rd_addr_b}),
    .out_vld  (wr_en),
    .out_data (wr_data)
  );

  assign wr_addr_a = wr_data[2*LOGN-1:LOGN];
  assign wr_addr_b = wr_data[LOGN-1:0];

endmodule

// File: tb/tb_fft_bf_sched.sv
module tb_fft_bf_sched;

  logic       clk, rst_n, go, quant_full, cm_req;
  logic       busy, done, rd_en, bf_start, wr_en, scale_en, cm_gnt;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0] tw_addr, scale_exp;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-derived read sequence for N=8: stage 0, 1, 2 in order.
  logic [2:0] A  [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
  logic [2:0] B  [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
  logic [1:0] TW [12] = '{0,1,2,3, 0,2,0,2, 0,0,0,0};

  logic [22:0] all_outs;
  assign all_outs = {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_start,
                     wr_en, wr_addr_a, wr_addr_b, scale_en, scale_exp, cm_gnt};

  fft_bf_sched #(.LOGN(3), .BF_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .bf_start(bf_start), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .quant_full(quant_full), .scale_en(scale_en), .scale_exp(scale_exp),
    .cm_req(cm_req), .cm_gnt(cm_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read stages occupy cycles 1-4, 10-13, 19-22 after go at cycle 0.
  function automatic int rd_idx(input int c);
    for (int s = 0; s < 3; s++)
      if (c >= 1 + 9*s && c <= 4 + 9*s) return 4*s + (c - 1 - 9*s);
    return -1;
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (all_outs !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0", all_outs);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_addr_sequence();
    logic [18:0] obs, exp;
    logic        e_rd, e_bs, e_wr;
    logic [2:0]  e_ra, e_rb, e_wa, e_wb;
    logic [1:0]  e_tw;
    int ir, ib, iw;
    @(negedge clk); go = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk); go = 1'b0;
      ir = rd_idx(c); ib = rd_idx(c - 1); iw = rd_idx(c - 5);
      e_rd = 0; e_ra = 0; e_rb = 0; e_tw = 0; e_wr = 0; e_wa = 0; e_wb = 0;
      e_bs = (ib >= 0);
      if (ir >= 0) begin e_rd = 1; e_ra = A[ir]; e_rb = B[ir]; e_tw = TW[ir]; end
      if (iw >= 0) begin e_wr = 1; e_wa = A[iw]; e_wb = B[iw]; end
      exp = {e_rd, e_ra, e_rb, e_tw, e_bs, e_wr, e_wa, e_wb,
             (c >= 1 && c <= 27), (c == 28)};
      obs = {rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_start, wr_en, wr_addr_a,
             wr_addr_b, busy, done};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL addr_seq c=%0d: got %b want %b", c, obs, exp);
      end
    end
  endtask

  task automatic test_scaling();
    logic [2:0] obs, exp;
    @(negedge clk); go = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk); go = 1'b0;
      exp = {(c >= 10 && c <= 18), (c >= 10) ? 2'd1 : 2'd0};
      obs = {scale_en, scale_exp};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL scaling c=%0d: got %b want %b", c, obs, exp);
      end
      // c=9: last stage-0 write on the last DRAIN cycle; c=20: no write, ignored.
      quant_full = (c == 9 || c == 20);
    end
    quant_full = 1'b0;
  endtask

  task automatic test_cm_grant();
    @(negedge clk); cm_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (cm_gnt !== 1'b1) begin
      n_fail++; $display("FAIL cm_gnt_idle: got %b want 1", cm_gnt);
    end
    go = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); go = 1'b0;
      n_checks++;
      if ({rd_en, busy, cm_gnt} !== 3'b001) begin
        n_fail++;
        $display("FAIL go_pend_hold i=%0d: got %b want 001", i, {rd_en, busy, cm_gnt});
      end
    end
    cm_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_en, busy, cm_gnt, rd_addr_a, rd_addr_b, scale_exp} !== {3'b110, 3'd0, 3'd4, 2'd0}) begin
      n_fail++;
      $display("FAIL go_pend_start: got %b want 110_000_100_00",
               {rd_en, busy, cm_gnt, rd_addr_a, rd_addr_b, scale_exp});
    end
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL pend_run_timeout: busy got %b want 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_busy_arb();
    logic [2:0] obs, exp;
    int n_done = 0;
    @(negedge clk); go = 1'b1;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      exp = {(c >= 29 && c <= 31), (c == 28), (c >= 1 && c <= 27)};
      obs = {cm_gnt, done, busy};
      if (done === 1'b1) n_done++;
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL busy_arb c=%0d: got gnt/done/busy %b want %b", c, obs, exp);
      end
      go     = (c == 5);
      cm_req = (c >= 3 && c <= 30);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++; $display("FAIL done_count: got %0d want 1", n_done);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_go_wins_reset_mid();
    @(negedge clk);
    n_checks++;
    if (cm_gnt !== 1'b0) begin
      n_fail++; $display("FAIL pre_gnt: got %b want 0", cm_gnt);
    end
    go = 1'b1; cm_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk); go = 1'b0;
      if (c == 1) begin
        n_checks++;
        if ({busy, rd_en, cm_gnt} !== 3'b110) begin
          n_fail++; $display("FAIL go_wins: got %b want 110", {busy, rd_en, cm_gnt});
        end
      end
    end
    n_checks++;
    if ({rd_en, rd_addr_a, rd_addr_b} !== {1'b1, 3'd4, 3'd6}) begin
      n_fail++;
      $display("FAIL mid_stage1_k2: got %b want 1100110", {rd_en, rd_addr_a, rd_addr_b});
    end
    rst_n = 1'b0; cm_req = 1'b0;
    #1;
    n_checks++;
    if (all_outs !== 23'd0) begin
      n_fail++; $display("FAIL async_reset: got %b want 0", all_outs);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if ({wr_en, busy, done, rd_en} !== 4'b0000) begin
        n_fail++;
        $display("FAIL post_reset i=%0d: got %b want 0000", i, {wr_en, busy, done, rd_en});
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; quant_full = 1'b0; cm_req = 1'b0;
    test_reset();
    test_addr_sequence();
    test_scaling();
    test_cm_grant();
    test_busy_arb();
    test_go_wins_reset_mid();
    test_addr_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
